uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver: the next-generation receive path for the echo design, which feeds the UART echo top (`clk`/`rst`/`rx`/`tx`/`led`). It oversamples the line and supports configurable data width and stop-bit count, plus optional parity. It reports frame, parity and overrun errors, and presents bytes on a valid/ready handshake with a one-entry holding register.

## Interface
- `CLK_FREQ`, 100_000_000: system clock in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥ 4.
- `DATA_BITS`, 8: payload bits per frame, 5..9.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even. Only used with `UART_RX_PARITY_EN`.

Ports:
- `clk`, input, 1: system clock; single clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `rx`, input, 1: asynchronous serial line; idles high.
- `rx_data`, output, `DATA_BITS`: received payload, LSB-first reassembled.
- `rx_valid`, output, 1: `rx_data` holds an unconsumed byte.
- `rx_ready`, input, 1: consumer accepts the byte.
- `frame_err`, output, 1: one-cycle pulse; a stop bit was sampled low.
- `parity_err`, output, 1: one-cycle pulse; parity mismatch. Tied 0 without the macro.
- `overrun`, output, 1: one-cycle pulse; a byte was dropped because the holding register was full.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser; the FSM sees only the synchronised value `rx_s`.
- Tick generator:
  - divisor = (CLK_FREQ + BAUD·OVERSAMPLE/2) / (BAUD·OVERSAMPLE), rounded; the default gives 651.
  - Emits a 1-cycle `tick`. Its counter restarts on every start-edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - **IDLE**: a falling edge of `rx_s` moves to START and clears the tick count.
  - **START**: at tick OVERSAMPLE/2, `rx_s` is re-checked. If low, go to DATA. If high (glitch), return to IDLE with no flags.
  - **DATA**: samples every OVERSAMPLE ticks from the start-bit mid-point, `DATA_BITS` samples, shifted in LSB-first. Then go to PARITY if the macro is defined, otherwise STOP.
  - **PARITY**: one sample, then go to STOP.
  - **STOP**: `STOP_BITS` samples.
    - All high: the frame completes.
    - Any stop sample low: `frame_err` pulses, the byte is discarded, and the FSM goes to WAIT_IDLE.
  - **WAIT_IDLE**: leave for IDLE only when `rx_s` = 1. This means a break does not generate repeated frames.
- Holding register and handshake:
  - A completed good frame loads `rx_data` and sets `rx_valid`.
  - `rx_valid` and `rx_data` stay stable until `rx_valid && rx_ready`, which clears `rx_valid` at that edge.
  - If a frame completes while `rx_valid` is set and `rx_ready` is low: `overrun` pulses, the new byte is dropped and the old byte is kept.
  - If a frame completes in the same cycle as a handshake: the new byte loads, `rx_valid` stays 1, and there is no overrun.
- Parity error:
  - `parity_err` pulses at the last stop sample, together with the frame completion.
  - The byte is still delivered, so the consumer decides what to do with it.
  - If the stop bit is also bad, only `frame_err` pulses.
- Reset mid-frame aborts reception: the FSM returns to IDLE and no flags are raised.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `overrun` = 0, `busy` = 0.
  - FSM in IDLE, synchroniser flops = 1.
- Edge detect latency: 2 cycles from the `rx` edge.
- `rx_valid` and any error pulses assert on the clock edge after the tick that samples the final stop bit.
  - Start edge to `rx_valid` ≈ (1 + DATA_BITS + P + STOP_BITS − 0.5) · OVERSAMPLE · divisor + 3 cycles, where P = 1 with parity, otherwise 0.
- Error pulses are exactly 1 cycle wide.
- `busy` rises 1 cycle after start detection and falls on the cycle the FSM enters IDLE.

## Configuration
- Macro `UART_RX_PARITY_EN`.
  - **Defined**: the PARITY state exists and one parity bit is expected after the data bits. Even or odd is selected by `PARITY_ODD`, and mismatches produce `parity_err`.
  - **Undefined**: the PARITY state is removed, the frame is start + data + stop, and `parity_err` is constant 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - Function `baud_div(clk_freq, baud, os)` implementing the rounded divisor.
  - Constants for the idle line level and the minimum OVERSAMPLE.
- Sub-module `uart_baud_tick`:
  - Parameter: divisor.
  - Inputs: `clk`, `rst`, `restart`. Output: `tick`.
  - The transmit path reuses it later.
- Top `uart_rx_param` contains the synchroniser, FSM, shift register and holding register.

## Test plan
- **Defaults, basic stream**: 9600 baud 8N1, bytes 0x30, 0x31, 0x32, 0x33, 0x34 with `rx_ready` = 1. Expect five `rx_valid` pulses with `rx_data` = 0x30..0x34 in order and no error flags.
- **Frame error and break**: drive the stop bit low on 0x55. Expect `frame_err` for 1 cycle, no `rx_valid`, and `busy` held high until `rx` returns high.
- **Overrun**: hold `rx_ready` = 0 and send 0xA5 then 0x5A. Expect `rx_data` = 0xA5 held and `overrun` to pulse once at the end of the second frame. Then assert `rx_ready`: `rx_valid` drops and no 0x5A is delivered.
- **Glitch rejection**: a low pulse on `rx` of 0.25 bit. Expect a return to IDLE with no outputs or flags.
- **Parity, with `UART_RX_PARITY_EN` and `PARITY_ODD` = 0**: send 0x07 with parity bit 1, which is correct. Expect delivery with no flag. Send 0x07 with parity bit 0: expect 0x07 delivered plus a `parity_err` pulse.
- **Width variants and reset**: `DATA_BITS` = 7, `STOP_BITS` = 2, 115200 baud, receive 0x41. Then assert `rst` at mid-data of the next frame: all outputs return to 0, and the following clean 0x42 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path and baud tick generator.
//   rx_state_e     : receiver FSM states
//   LINE_IDLE      : idle (mark) level of the serial line
//   MIN_OVERSAMPLE : smallest oversampling factor the receiver supports
//   baud_div()     : rounded clock divisor producing one tick per oversample period
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  localparam logic LINE_IDLE      = 1'b1;
  localparam int   MIN_OVERSAMPLE = 4;

  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a one-cycle tick every DIV clocks.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   restart : zero the divider so the next tick lands DIV cycles later
//   tick    : one-cycle pulse, once per DIV clocks
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with a one-entry holding register.
//   clk, rst   : system clock, synchronous active-high reset
//   rx         : asynchronous serial input, idles high
//   rx_data    : received payload, LSB-first
//   rx_valid   : rx_data holds an unconsumed byte (cleared by rx_valid && rx_ready)
//   rx_ready   : consumer accepts the byte
//   frame_err  : one-cycle pulse, a stop bit sampled low
//   parity_err : one-cycle pulse, parity mismatch (constant 0 without parity)
//   overrun    : one-cycle pulse, a completed byte was dropped (holding register full)
//   busy       : FSM is not idle
// Build option: define UART_RX_PARITY_EN to expect one parity bit after the data
// bits (even or odd chosen by PARITY_ODD).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_EFF = (OVERSAMPLE < MIN_OVERSAMPLE) ? MIN_OVERSAMPLE : OVERSAMPLE;
  localparam int DIV    = baud_div(CLK_FREQ, BAUD, OS_EFF);
  localparam int OSW    = $clog2(OS_EFF);

  localparam logic [OSW-1:0] HALF_LAST = OSW'(OS_EFF / 2 - 1);
  localparam logic [OSW-1:0] FULL_LAST = OSW'(OS_EFF - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

  logic [2:0]           sync_q;
  logic                 rx_s;
  logic                 rx_prev;
  logic                 tick;
  logic                 start_edge;
  logic                 samp;
  logic                 last_stop;
  logic                 good_frame;
  rx_state_e            state_q;
  logic [OSW-1:0]       os_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 stop_ok_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic par_q;
  logic par_bad_q;
  logic parity_err_q;
`endif

  // Two synchroniser flops, then a third flop holding the previous rx_s for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {3{LINE_IDLE}};
    end else begin
      sync_q <= {sync_q[1:0], rx};
    end
  end

  assign rx_s       = sync_q[1];
  assign rx_prev    = sync_q[2];
  assign start_edge = (state_q == ST_IDLE) && rx_prev && !rx_s;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(start_edge),
    .tick   (tick)
  );

  // The start bit is judged half a bit in; every later sample is a full bit apart,
  // which keeps all samples at bit centres.
  always_comb begin
    samp = 1'b0;
    if (tick && (state_q != ST_IDLE) && (state_q != ST_WAIT_IDLE)) begin
      samp = (state_q == ST_START) ? (os_cnt_q == HALF_LAST) : (os_cnt_q == FULL_LAST);
    end
  end

  assign last_stop  = samp && (state_q == ST_STOP) && (bit_cnt_q == STOP_LAST);
  assign good_frame = last_stop && stop_ok_q && rx_s;
  assign shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      stop_ok_q   <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      if (state_q == ST_IDLE) begin
        os_cnt_q <= '0;
      end else if (tick) begin
        os_cnt_q <= samp ? '0 : os_cnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (samp) begin
            if (!rx_s) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
              par_q     <= 1'b0;
`endif
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (samp) begin
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_q ^ rx_s;
`endif
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
              stop_ok_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              state_q   <= ST_PARITY;
`else
              state_q   <= ST_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (samp) begin
            par_bad_q <= par_q ^ rx_s ^ PAR_SENSE;
            state_q   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (last_stop) begin
            frame_err_q <= !good_frame;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= good_frame && par_bad_q;
`endif
            state_q     <= good_frame ? ST_IDLE : ST_WAIT_IDLE;
          end else if (samp) begin
            stop_ok_q <= stop_ok_q & rx_s;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          // Held here through a break so a stuck-low line yields one error, not a stream.
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Handshake first; a same-cycle completion below overrides the clear.
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (good_frame) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0 && (PARITY_ODD != 0);
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int P      = PAR_EN ? 1 : 0;
  localparam int OS     = 16;
  localparam int DIV_A  = 4;
  localparam int DIV_B  = 3;
  localparam int BC_A   = OS * DIV_A;
  localparam int BC_B   = OS * DIV_B;
  localparam int LAT_A  = (OS / 2) * DIV_A * (2 * (1 + 8 + P + 1) - 1) + 3;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic rx_ready_a = 1'b1, rx_ready_b = 1'b1;
  logic [7:0] rx_data_a;
  logic [6:0] rx_data_b;
  logic rx_valid_a, frame_err_a, parity_err_a, overrun_a, busy_a;
  logic rx_valid_b, frame_err_b, parity_err_b, overrun_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ(9600 * OS * DIV_A), .BAUD(9600), .OVERSAMPLE(OS),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .rx(rx_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_ready(rx_ready_a), .frame_err(frame_err_a), .parity_err(parity_err_a),
    .overrun(overrun_a), .busy(busy_a)
  );

  uart_rx_param #(
    .CLK_FREQ(115200 * OS * DIV_B), .BAUD(115200), .OVERSAMPLE(OS),
    .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .rx(rx_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_ready(rx_ready_b), .frame_err(frame_err_b), .parity_err(parity_err_b),
    .overrun(overrun_b), .busy(busy_b)
  );

  // Passive monitors: accepted bytes, cycles each error flag is high, valid rise time.
  int cyc = 0;
  logic [7:0] got_a [256];
  logic [6:0] got_b [256];
  int n_got_a = 0, n_ferr_a = 0, n_perr_a = 0, n_ovr_a = 0, rise_cyc_a = 0;
  int n_got_b = 0, n_ferr_b = 0, n_perr_b = 0, n_ovr_b = 0;
  logic vld_prev_a = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid_a && rx_ready_a) begin
      got_a[n_got_a % 256] <= rx_data_a;
      n_got_a <= n_got_a + 1;
    end
    if (frame_err_a)  n_ferr_a <= n_ferr_a + 1;
    if (parity_err_a) n_perr_a <= n_perr_a + 1;
    if (overrun_a)    n_ovr_a  <= n_ovr_a + 1;
    if (rx_valid_a && !vld_prev_a) rise_cyc_a <= cyc;
    vld_prev_a <= rx_valid_a;
    if (rx_valid_b && rx_ready_b) begin
      got_b[n_got_b % 256] <= rx_data_b;
      n_got_b <= n_got_b + 1;
    end
    if (frame_err_b)  n_ferr_b <= n_ferr_b + 1;
    if (parity_err_b) n_perr_b <= n_perr_b + 1;
    if (overrun_b)    n_ovr_b  <= n_ovr_b + 1;
  end

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic v);
    if (w == 0) rx_a = v;
    else        rx_b = v;
  endtask

  // Start, data LSB-first, optional parity, stop bits; leaves the line at the last stop level.
  task automatic send_body(input int w, input logic [7:0] d, input bit stop_bad, input bit par_flip);
    int  nb, ns, bc;
    bit  pbit;
    nb = (w == 0) ? 8 : 7;
    ns = (w == 0) ? 1 : 2;
    bc = (w == 0) ? BC_A : BC_B;
    pbit = par_flip;
    drive(w, 1'b0);
    wait_cyc(bc);
    for (int i = 0; i < nb; i++) begin
      drive(w, d[i]);
      pbit = pbit ^ d[i];
      wait_cyc(bc);
    end
    if (PAR_EN) begin
      drive(w, pbit);
      wait_cyc(bc);
    end
    for (int i = 0; i < ns; i++) begin
      drive(w, !stop_bad);
      wait_cyc(bc);
    end
  endtask

  task automatic send_frame(input int w, input logic [7:0] d, input bit stop_bad, input bit par_flip);
    send_body(w, d, stop_bad, par_flip);
    drive(w, 1'b1);
    wait_cyc((w == 0) ? BC_A : BC_B);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_bad;
    bit         par_flip;
    int         exp_got;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_q[$];
  int s_got, s_ferr, s_perr, s_ovr, t0;
  logic [7:0] rd;
  bit rsb, rpf;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{8'h30, 1'b0, 1'b0, 1, 8'h30, 0, 0});
    vecs.push_back('{8'h31, 1'b0, 1'b0, 1, 8'h31, 0, 0});
    vecs.push_back('{8'h32, 1'b0, 1'b0, 1, 8'h32, 0, 0});
    vecs.push_back('{8'h33, 1'b0, 1'b0, 1, 8'h33, 0, 0});
    vecs.push_back('{8'h34, 1'b0, 1'b0, 1, 8'h34, 0, 0});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 1, 8'h00, 0, 0});
    vecs.push_back('{8'hFF, 1'b0, 1'b0, 1, 8'hFF, 0, 0});
    vecs.push_back('{8'hC3, 1'b1, 1'b0, 0, 8'h00, 1, 0});
    if (PAR_EN) begin
      vecs.push_back('{8'h07, 1'b0, 1'b0, 1, 8'h07, 0, 0});
      vecs.push_back('{8'h07, 1'b0, 1'b1, 1, 8'h07, 0, 1});
      vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 8'h00, 1, 0});
    end

    // Reset state
    wait_cyc(5);
    chk("reset rx_valid_a", rx_valid_a, 0);
    chk("reset rx_data_a", rx_data_a, 0);
    chk("reset busy_a", busy_a, 0);
    chk("reset flags_a", {frame_err_a, parity_err_a, overrun_a}, 0);
    chk("reset rx_valid_b", rx_valid_b, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    wait_cyc(BC_A);

    // Table-driven frames on the 8-bit receiver
    foreach (vecs[i]) begin
      s_got = n_got_a; s_ferr = n_ferr_a; s_perr = n_perr_a; s_ovr = n_ovr_a;
      t0 = cyc;
      send_frame(0, vecs[i].data, vecs[i].stop_bad, vecs[i].par_flip);
      chk($sformatf("vec%0d bytes", i), n_got_a - s_got, vecs[i].exp_got);
      if (vecs[i].exp_got == 1) begin
        chk($sformatf("vec%0d data", i), got_a[(n_got_a - 1) % 256], vecs[i].exp_data);
        chk($sformatf("vec%0d latency", i), rise_cyc_a - t0, LAT_A);
      end
      chk($sformatf("vec%0d frame_err", i), n_ferr_a - s_ferr, vecs[i].exp_ferr);
      chk($sformatf("vec%0d parity_err", i), n_perr_a - s_perr, vecs[i].exp_perr);
      chk($sformatf("vec%0d overrun", i), n_ovr_a - s_ovr, 0);
      chk($sformatf("vec%0d idle", i), busy_a, 0);
    end

    // Frame error followed by a break
    s_got = n_got_a; s_ferr = n_ferr_a;
    send_body(0, 8'h55, 1'b1, 1'b0);
    wait_cyc(3 * BC_A);
    chk("break busy held", busy_a, 1);
    chk("break frame_err once", n_ferr_a - s_ferr, 1);
    chk("break no byte", n_got_a - s_got, 0);
    drive(0, 1'b1);
    wait_cyc(BC_A);
    chk("break released busy", busy_a, 0);

    // Overrun
    rx_ready_a = 1'b0;
    s_got = n_got_a; s_ovr = n_ovr_a;
    send_frame(0, 8'hA5, 1'b0, 1'b0);
    send_frame(0, 8'h5A, 1'b0, 1'b0);
    chk("overrun pulse", n_ovr_a - s_ovr, 1);
    chk("overrun valid held", rx_valid_a, 1);
    chk("overrun data held", rx_data_a, 8'hA5);
    rx_ready_a = 1'b1;
    wait_cyc(2);
    chk("overrun drained valid", rx_valid_a, 0);
    chk("overrun one byte", n_got_a - s_got, 1);
    chk("overrun byte value", got_a[(n_got_a - 1) % 256], 8'hA5);

    // Glitch of a quarter bit
    s_got = n_got_a; s_ferr = n_ferr_a; s_perr = n_perr_a;
    drive(0, 1'b0);
    wait_cyc(BC_A / 4);
    drive(0, 1'b1);
    wait_cyc(4);
    chk("glitch edge seen", busy_a, 1);
    wait_cyc(BC_A);
    chk("glitch back idle", busy_a, 0);
    chk("glitch no byte", n_got_a - s_got, 0);
    chk("glitch no flags", (n_ferr_a - s_ferr) + (n_perr_a - s_perr), 0);

    // Randomised frames against the rule model
    for (int i = 0; i < 20; i++) begin
      rd  = 8'($urandom);
      rsb = ($urandom_range(0, 7) == 0);
      rpf = PAR_EN && ($urandom_range(0, 3) == 0);
      if (!rsb) exp_q.push_back(rd);
      s_got = n_got_a; s_ferr = n_ferr_a; s_perr = n_perr_a;
      send_frame(0, rd, rsb, rpf);
      chk($sformatf("rnd%0d bytes", i), n_got_a - s_got, rsb ? 0 : 1);
      if (!rsb) chk($sformatf("rnd%0d data", i), got_a[(n_got_a - 1) % 256], exp_q.pop_front());
      chk($sformatf("rnd%0d frame_err", i), n_ferr_a - s_ferr, rsb ? 1 : 0);
      chk($sformatf("rnd%0d parity_err", i), n_perr_a - s_perr, (rpf && !rsb) ? 1 : 0);
    end

    // 7 data bits, 2 stop bits, 115200 baud; reset mid-frame
    rx_ready_b = 1'b0;
    send_frame(1, 8'h41, 1'b0, 1'b0);
    chk("b 0x41 valid", rx_valid_b, 1);
    chk("b 0x41 data", rx_data_b, 7'h41);
    s_ferr = n_ferr_b; s_perr = n_perr_b; s_ovr = n_ovr_b;
    fork
      send_frame(1, 8'h2D, 1'b0, 1'b0);
      begin
        wait_cyc(BC_B * 4);
        rst_b = 1'b1;
        wait_cyc(2);
        chk("b reset valid", rx_valid_b, 0);
        chk("b reset data", rx_data_b, 0);
        chk("b reset busy", busy_b, 0);
      end
    join
    rst_b = 1'b0;
    chk("b reset no flags", (n_ferr_b - s_ferr) + (n_perr_b - s_perr) + (n_ovr_b - s_ovr), 0);
    rx_ready_b = 1'b1;
    s_got = n_got_b;
    send_frame(1, 8'h42, 1'b0, 1'b0);
    chk("b 0x42 bytes", n_got_b - s_got, 1);
    chk("b 0x42 data", got_b[(n_got_b - 1) % 256], 7'h42);
    chk("b frame_err none", n_ferr_b - s_ferr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
